// File: rtl/pipeline_hazard_unit_if.sv
// Forwarding/stall/flush bundle between the ARM datapath and its hazard unit.
// With HAZARD_STATS_EN defined it also carries the saturating statistics counters.
interface pipeline_hazard_unit_if
`ifdef HAZARD_STATS_EN
  #(parameter int CNT_W = 16)
`endif
  ;
  logic [4:0] match;
  logic       RegWriteD;
  logic       MemtoRegD;
  logic       PCSrcD;
  logic       CondExE;
  logic       BranchTakenE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic       RegWriteW;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] fwd_cnt;

  modport master (
    output match, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, RegWriteW,
    input  stall_cnt, flush_cnt, fwd_cnt
  );

  modport slave (
    input  match, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, RegWriteW,
    output stall_cnt, flush_cnt, fwd_cnt
  );
`else
  modport master (
    output match, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, RegWriteW
  );

  modport slave (
    input  match, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, RegWriteW
  );
`endif
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage ARM pipeline: forwarding selects, load-use and
// PC-write stalls, branch flushes. Optional statistics counters under HAZARD_STATS_EN.
module pipeline_hazard_unit
`ifdef HAZARD_STATS_EN
  #(parameter int CNT_W = 16)
`endif
  (
  input logic             clk,
  input logic             reset,
  pipeline_hazard_unit_if.slave hz
);

  logic       regwrite_e_r;
  logic       memtoreg_e_r;
  logic       pcsrc_e_r;
  logic       regwrite_m_r;
  logic       pcsrc_m_r;
  logic       regwrite_w_r;
  logic       pcsrc_w_r;

  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;
  logic       ldr_stall_s;
  logic       pc_wr_pending_s;
  logic       stall_f_s;
  logic       stall_d_s;
  logic       flush_d_s;
  logic       flush_e_s;

  // Shadow pipeline of hazard-relevant control bits; a flushed E slot becomes a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_e_r <= 1'b0;
      memtoreg_e_r <= 1'b0;
      pcsrc_e_r    <= 1'b0;
      regwrite_m_r <= 1'b0;
      pcsrc_m_r    <= 1'b0;
      regwrite_w_r <= 1'b0;
      pcsrc_w_r    <= 1'b0;
    end else begin
      if (flush_e_s) begin
        regwrite_e_r <= 1'b0;
        memtoreg_e_r <= 1'b0;
        pcsrc_e_r    <= 1'b0;
      end else begin
        regwrite_e_r <= hz.RegWriteD;
        memtoreg_e_r <= hz.MemtoRegD;
        pcsrc_e_r    <= hz.PCSrcD;
      end
      // An instruction whose condition failed must not write anything downstream.
      regwrite_m_r <= regwrite_e_r & hz.CondExE;
      pcsrc_m_r    <= pcsrc_e_r & hz.CondExE;
      regwrite_w_r <= regwrite_m_r;
      pcsrc_w_r    <= pcsrc_m_r;
    end
  end

  // Forwarding selects; the younger M-stage result wins over W.
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (hz.match[3] && regwrite_m_r) begin
      fwd_a_s = 2'b10;
    end else if (hz.match[1] && regwrite_w_r) begin
      fwd_a_s = 2'b01;
    end else begin
      fwd_a_s = 2'b00;
    end
    if (hz.match[2] && regwrite_m_r) begin
      fwd_b_s = 2'b10;
    end else if (hz.match[0] && regwrite_w_r) begin
      fwd_b_s = 2'b01;
    end else begin
      fwd_b_s = 2'b00;
    end
  end

  assign ldr_stall_s     = hz.match[4] & memtoreg_e_r;
  assign pc_wr_pending_s = hz.PCSrcD | pcsrc_e_r | pcsrc_m_r;
  assign stall_f_s       = ldr_stall_s | pc_wr_pending_s;
  assign stall_d_s       = ldr_stall_s;
  assign flush_d_s       = pc_wr_pending_s | pcsrc_w_r | hz.BranchTakenE;
  assign flush_e_s       = ldr_stall_s | hz.BranchTakenE;

  assign hz.ForwardAE = fwd_a_s;
  assign hz.ForwardBE = fwd_b_s;
  assign hz.StallF    = stall_f_s;
  assign hz.StallD    = stall_d_s;
  assign hz.FlushD    = flush_d_s;
  assign hz.FlushE    = flush_e_s;
  assign hz.RegWriteW = regwrite_w_r;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0] fwd_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != {CNT_W{1'b1}})) begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Event counters, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
      fwd_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= sat_inc(stall_cnt_r, stall_f_s);
      flush_cnt_r <= sat_inc(flush_cnt_r, flush_d_s | flush_e_s);
      fwd_cnt_r   <= sat_inc(fwd_cnt_r, (fwd_a_s != 2'b00) | (fwd_b_s != 2'b00));
    end
  end

  assign hz.stall_cnt = stall_cnt_r;
  assign hz.flush_cnt = flush_cnt_r;
  assign hz.fwd_cnt   = fwd_cnt_r;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed self-checking bench for pipeline_hazard_unit (counter test needs HAZARD_STATS_EN).
module tb_pipeline_hazard_unit;

  logic clk;
  logic reset;
  int   passed;
  int   failed;
  int   total;

`ifdef HAZARD_STATS_EN
  pipeline_hazard_unit_if #(.CNT_W(4)) hz ();
  pipeline_hazard_unit #(.CNT_W(4)) dut (.clk(clk), .reset(reset), .hz(hz));
`else
  pipeline_hazard_unit_if hz ();
  pipeline_hazard_unit dut (.clk(clk), .reset(reset), .hz(hz));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    reset  = 1'b1;
    hz.match        = 5'b00000;
    hz.RegWriteD    = 1'b0;
    hz.MemtoRegD    = 1'b0;
    hz.PCSrcD       = 1'b0;
    hz.CondExE      = 1'b0;
    hz.BranchTakenE = 1'b0;

    // 1: reset state, then asynchronous reset mid-stream
    tick();
    chk("rst_fwda", {14'd0, hz.ForwardAE}, 16'd0);
    chk("rst_fwdb", {14'd0, hz.ForwardBE}, 16'd0);
    chk("rst_stallf", {15'd0, hz.StallF}, 16'd0);
    chk("rst_stalld", {15'd0, hz.StallD}, 16'd0);
    chk("rst_flushd", {15'd0, hz.FlushD}, 16'd0);
    chk("rst_flushe", {15'd0, hz.FlushE}, 16'd0);
    chk("rst_regww", {15'd0, hz.RegWriteW}, 16'd0);
    tick();
    reset = 1'b0;
    hz.CondExE = 1'b1;
    hz.PCSrcD = 1'b1;
    #1 chk("pcd_stallf", {15'd0, hz.StallF}, 16'd1);
    tick();
    hz.PCSrcD = 1'b0;
    #1 chk("pce_stallf", {15'd0, hz.StallF}, 16'd1);
    reset = 1'b1;
    #1 chk("midrst_stallf", {15'd0, hz.StallF}, 16'd0);
    chk("midrst_flushd", {15'd0, hz.FlushD}, 16'd0);
    tick();
    reset = 1'b0;

    // 2: forwarding from M, M+W, W only, and M priority
    hz.RegWriteD = 1'b1;
    tick();
    hz.RegWriteD = 1'b0;
    tick();
    hz.match = 5'b01000;
    #1 chk("fwd_m_a", {14'd0, hz.ForwardAE}, 16'd2);
    chk("fwd_m_b", {14'd0, hz.ForwardBE}, 16'd0);
    hz.match = 5'b01010;
    #1 chk("fwd_mw_a", {14'd0, hz.ForwardAE}, 16'd2);
    tick();
    hz.match = 5'b00001;
    #1 chk("fwd_w_b", {14'd0, hz.ForwardBE}, 16'd1);
    chk("fwd_w_a", {14'd0, hz.ForwardAE}, 16'd0);
    chk("regww_fwd", {15'd0, hz.RegWriteW}, 16'd1);
    hz.match = 5'b01010;
    #1 chk("fwd_wonly_a", {14'd0, hz.ForwardAE}, 16'd1);
    hz.match = 5'b00000;
    tick(); tick(); tick();
    hz.RegWriteD = 1'b1;
    tick(); tick();
    hz.RegWriteD = 1'b0;
    tick();
    hz.match = 5'b01010;
    #1 chk("prio_a", {14'd0, hz.ForwardAE}, 16'd2);
    hz.match = 5'b00101;
    #1 chk("prio_b", {14'd0, hz.ForwardBE}, 16'd2);
    hz.match = 5'b00000;
    tick(); tick(); tick();

    // 3: load-use stall lasts one cycle, then W forwarding
    hz.MemtoRegD = 1'b1;
    hz.RegWriteD = 1'b1;
    tick();
    hz.MemtoRegD = 1'b0;
    hz.RegWriteD = 1'b0;
    hz.match = 5'b10000;
    #1 chk("ld_stallf", {15'd0, hz.StallF}, 16'd1);
    chk("ld_stalld", {15'd0, hz.StallD}, 16'd1);
    chk("ld_flushe", {15'd0, hz.FlushE}, 16'd1);
    chk("ld_flushd", {15'd0, hz.FlushD}, 16'd0);
    tick();
    chk("ld2_stallf", {15'd0, hz.StallF}, 16'd0);
    chk("ld2_stalld", {15'd0, hz.StallD}, 16'd0);
    chk("ld2_flushe", {15'd0, hz.FlushE}, 16'd0);
    tick();
    hz.match = 5'b00010;
    #1 chk("ld_fwd_w", {14'd0, hz.ForwardAE}, 16'd1);
    hz.match = 5'b00000;
    tick(); tick(); tick();

    // 4: PC write, condition passed: StallF 3 cycles, FlushD 4 cycles
    hz.RegWriteD = 1'b1;
    hz.PCSrcD = 1'b1;
    #1 chk("pc_d_stallf", {15'd0, hz.StallF}, 16'd1);
    chk("pc_d_flushd", {15'd0, hz.FlushD}, 16'd1);
    tick();
    hz.RegWriteD = 1'b0;
    hz.PCSrcD = 1'b0;
    #1 chk("pc_e_stallf", {15'd0, hz.StallF}, 16'd1);
    chk("pc_e_flushd", {15'd0, hz.FlushD}, 16'd1);
    tick();
    chk("pc_m_stallf", {15'd0, hz.StallF}, 16'd1);
    chk("pc_m_flushd", {15'd0, hz.FlushD}, 16'd1);
    tick();
    chk("pc_w_stallf", {15'd0, hz.StallF}, 16'd0);
    chk("pc_w_flushd", {15'd0, hz.FlushD}, 16'd1);
    chk("pc_w_regww", {15'd0, hz.RegWriteW}, 16'd1);
    tick();
    chk("pc_end_flushd", {15'd0, hz.FlushD}, 16'd0);
    chk("pc_end_regww", {15'd0, hz.RegWriteW}, 16'd0);

    // 4b: PC write, condition failed: StallF and FlushD 2 cycles
    hz.RegWriteD = 1'b1;
    hz.PCSrcD = 1'b1;
    tick();
    hz.RegWriteD = 1'b0;
    hz.PCSrcD = 1'b0;
    hz.CondExE = 1'b0;
    #1 chk("nc_e_stallf", {15'd0, hz.StallF}, 16'd1);
    chk("nc_e_flushd", {15'd0, hz.FlushD}, 16'd1);
    tick();
    chk("nc_m_stallf", {15'd0, hz.StallF}, 16'd0);
    chk("nc_m_flushd", {15'd0, hz.FlushD}, 16'd0);
    tick();
    chk("nc_w_regww", {15'd0, hz.RegWriteW}, 16'd0);
    chk("nc_w_flushd", {15'd0, hz.FlushD}, 16'd0);
    hz.CondExE = 1'b1;
    tick();

    // 5: branch taken coincident with load-use stall; E becomes a bubble
    hz.MemtoRegD = 1'b1;
    hz.RegWriteD = 1'b1;
    tick();
    hz.MemtoRegD = 1'b0;
    hz.RegWriteD = 1'b0;
    hz.match = 5'b10000;
    hz.BranchTakenE = 1'b1;
    #1 chk("br_flushd", {15'd0, hz.FlushD}, 16'd1);
    chk("br_flushe", {15'd0, hz.FlushE}, 16'd1);
    chk("br_stalld", {15'd0, hz.StallD}, 16'd1);
    chk("br_stallf", {15'd0, hz.StallF}, 16'd1);
    hz.PCSrcD = 1'b1;
    hz.MemtoRegD = 1'b1;
    hz.RegWriteD = 1'b1;
    tick();
    hz.PCSrcD = 1'b0;
    hz.MemtoRegD = 1'b0;
    hz.RegWriteD = 1'b0;
    hz.BranchTakenE = 1'b0;
    #1 chk("bub_stallf", {15'd0, hz.StallF}, 16'd0);
    chk("bub_stalld", {15'd0, hz.StallD}, 16'd0);
    chk("bub_flushe", {15'd0, hz.FlushE}, 16'd0);
    chk("bub_flushd", {15'd0, hz.FlushD}, 16'd0);
    hz.match = 5'b00000;
    tick(); tick(); tick();

`ifdef HAZARD_STATS_EN
    // 6: stall counter saturation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("cnt_rst", hz.stall_cnt, 16'd0);
    hz.match = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      hz.MemtoRegD = 1'b1;
      tick();
      hz.MemtoRegD = 1'b0;
      tick();
    end
    chk("cnt_5", hz.stall_cnt, 16'd5);
    for (int i = 0; i < 15; i++) begin
      hz.MemtoRegD = 1'b1;
      tick();
      hz.MemtoRegD = 1'b0;
      tick();
    end
    chk("cnt_sat", hz.stall_cnt, 16'd15);
    chk("flush_sat", hz.flush_cnt, 16'd15);
    chk("fwd_zero", hz.fwd_cnt, 16'd0);
    hz.match = 5'b00000;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Hazard controller for the 5-stage pipelined ARM core. It is the consumer of the datapath's `match` vector and the producer of its forwarding selects and stall/flush strobes.
- It holds its own shadow pipeline of hazard-relevant control bits: RegWrite, MemtoReg and PC-write, carried through the D→E→M→W stages.
- Forwarding, load-use stalls, PC-write stalls and branch flushes are resolved the same cycle they are detected.

Parameters:
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk, input, 1, core clock; all registers update on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- match, input, 5, {match_12D_E, match_1E_M, match_2E_M, match_1E_W, match_2E_W}.
  - Bit 4 = (RA1D==WA3E) OR (RA2D==WA3E).
- RegWriteD, input, 1, instruction in Decode writes the register file.
- MemtoRegD, input, 1, instruction in Decode is a load.
- PCSrcD, input, 1, instruction in Decode writes R15.
- CondExE, input, 1, condition of the Execute-stage instruction passed.
- BranchTakenE, input, 1, branch resolved taken in Execute.
- ForwardAE, output, 2, SrcA select: 00 RD1E, 01 ResultW, 10 ALUOutM.
- ForwardBE, output, 2, SrcB/WriteData select, same encoding.
- StallF, output, 1, hold PC.
- StallD, output, 1, hold the F/D register.
- FlushD, output, 1, clear the F/D register.
- FlushE, output, 1, clear the D/E register.
- RegWriteW, output, 1, shadowed write-enable in Writeback, for debug/cross-check.

Behaviour:
- Shadow registers:
  - E stage: RegWriteE, MemtoRegE, PCSrcE.
  - M stage: RegWriteM, PCSrcM.
  - W stage: RegWriteW, PCSrcW.
  - All clear to 0 asynchronously on reset.
- D→E transfer: each edge, E-stage bits <= D inputs, unless FlushE=1; then E bits <= 0 (bubble). StallD does not affect D→E.
- E→M transfer: RegWriteM <= RegWriteE & CondExE; PCSrcM <= PCSrcE & CondExE. MemtoReg is not needed past E.
- M→W transfer: plain copy.
- Forwarding, purely combinational:
  - ForwardAE = 10 if match[3] & RegWriteM; else 01 if match[1] & RegWriteW; else 00.
  - ForwardBE = 10 if match[2] & RegWriteM; else 01 if match[0] & RegWriteW; else 00.
  - M-stage priority over W when both match.
- Derived conditions:
  - LDRstall = match[4] & MemtoRegE.
  - PCWrPending = PCSrcD | PCSrcE | PCSrcM.
- Strobes:
  - StallF = LDRstall | PCWrPending.
  - StallD = LDRstall.
  - FlushD = PCWrPending | PCSrcW | BranchTakenE.
  - FlushE = LDRstall | BranchTakenE.
- Latency:
  - Forward/stall/flush outputs respond the same cycle as their inputs.
  - Shadow state advances one stage per clock.
  - A PC-writing instruction holds StallF for exactly 3 cycles (D, E, M). FlushD is asserted 4 cycles (D, E, M, W).
- Simultaneous events:
  - LDRstall with BranchTakenE: FlushE=1 and StallD=1. The branch wins; the stalled D instruction is then discarded by FlushD on the following PC redirect.
  - PCSrcW and LDRstall: both strobes asserted.
- Reset mid-operation: all shadow bits clear immediately, without waiting for a clock edge. With the match/D inputs at 0, every output reads 0 while reset is high.
- The unit has no handshake; it never blocks on its own. A deadlock-free guarantee follows: LDRstall lasts at most 1 cycle, because the bubble clears MemtoRegE.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, the block adds:
  - Outputs stall_cnt[CNT_W-1:0], flush_cnt[CNT_W-1:0] and fwd_cnt[CNT_W-1:0].
  - Each counter increments on every cycle in which, respectively, StallF, (FlushD|FlushE), or (ForwardAE!=00 | ForwardBE!=00) holds.
  - Counters saturate at all-ones (no wrap) and clear on reset.
- When undefined: these ports and registers do not exist, and the block behaves identically otherwise.

Test Plan:
1. Reset=1 with all inputs 0 → all outputs 0. Pulse reset mid-stream with PCSrcE=1 → StallF drops in the same cycle.
2. RegWriteD=1, then two cycles later match=5'b01000 → ForwardAE=10. Same with match=5'b01010 → still 10. Set match=5'b00001 with only W valid → ForwardBE=01.
3. Load: MemtoRegD=1, RegWriteD=1; next cycle match[4]=1 → StallF=StallD=FlushE=1 for exactly 1 cycle, then 0. The following cycle, match[1]=1 → ForwardAE=01.
4. PCSrcD=1 for one cycle, CondExE=1 → StallF high 3 cycles, FlushD high 4 cycles, RegWriteW tracks RegWriteD 3 cycles later. Repeat with CondExE=0 → StallF 2 cycles, FlushD 2 cycles.
5. BranchTakenE=1 coincident with LDRstall → FlushD=FlushE=1 and StallD=1. Next cycle, E-stage shadow bits are 0.
6. With HAZARD_STATS_EN and CNT_W=4: hold match[4]=1 with a load injected every other cycle for 20 stall cycles → stall_cnt saturates at 15.
